// File: rtl/uart_resp_checker.sv
// Scoreboard for a UART transmitter: receives serial frames on rxd and compares them in order
// against a FIFO of expected bytes, keeping saturating event counters and pass/done/timeout status.
module uart_resp_checker #(
  parameter int CLK_PER_HALF_BIT = 30,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int DEPTH            = 16,
  parameter int TIMEOUT_CYC      = 1000000,
  parameter int CNT_W            = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] exp_data,
  input  logic                 exp_last,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     extra_cnt,
  output logic [CNT_W-1:0]     frame_err_cnt,
  output logic [CNT_W-1:0]     parity_err_cnt,
  output logic [CNT_W-1:0]     mis_index,
  output logic [DATA_BITS-1:0] mis_exp,
  output logic [DATA_BITS-1:0] mis_got,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int BC_W = $clog2(2 * CLK_PER_HALF_BIT + 1);
  localparam int BI_W = $clog2(DATA_BITS + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BC_W-1:0]  HALF_M1  = BC_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [BC_W-1:0]  FULL_M1  = BC_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [BI_W-1:0]  LAST_BIT = BI_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  function automatic logic par_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = ^{d, p};
    case (PARITY)
      1:       par_err = ~x;
      2:       par_err = x;
      default: par_err = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic                 sync1_q, sync2_q;
  state_e               state_q, state_d;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic [BI_W-1:0]      bidx_q, bidx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 evt_q, evt_d;
  logic [DATA_BITS-1:0] evt_data_q, evt_data_d;
  logic                 evt_ferr_q, evt_ferr_d, evt_perr_q, evt_perr_d;

  // Receiver: each sample is taken on the last cycle of a half/full bit period.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q + BC_W'(1);
    bidx_d     = bidx_q;
    sh_d       = sh_q;
    par_d      = par_q;
    evt_d      = 1'b0;
    evt_data_d = evt_data_q;
    evt_ferr_d = evt_ferr_q;
    evt_perr_d = evt_perr_q;
    case (state_q)
      S_IDLE: begin
        bcnt_d  = '0;
        bidx_d  = '0;
        state_d = sync2_q ? S_IDLE : S_START;
      end
      S_START: begin
        if (bcnt_q == HALF_M1) begin
          bcnt_d  = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d = '0;
          sh_d   = {sync2_q, sh_q[DATA_BITS-1:1]};
          bidx_d = bidx_q + BI_W'(1);
          if (bidx_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (bcnt_q == FULL_M1) begin
          bcnt_d  = '0;
          par_d   = sync2_q;
          state_d = S_STOP;
        end else begin
          state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (bcnt_q == FULL_M1) begin
          state_d    = S_IDLE;
          evt_d      = 1'b1;
          evt_data_d = sh_q;
          evt_ferr_d = ~sync2_q;
          evt_perr_d = par_err(sh_q, par_q);
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver registers; a reset mid-frame simply drops the partial frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      evt_q      <= 1'b0;
      evt_data_q <= '0;
      evt_ferr_q <= 1'b0;
      evt_perr_q <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      evt_q      <= evt_d;
      evt_data_q <= evt_data_d;
      evt_ferr_q <= evt_ferr_d;
      evt_perr_q <= evt_perr_d;
    end
  end

  logic [DATA_BITS:0]   mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     match_q, match_d, mis_q, mis_d, extra_q, extra_d;
  logic [CNT_W-1:0]     ferr_q, ferr_d, perr_q, perr_d, cmp_q, cmp_d, midx_q, midx_d;
  logic [DATA_BITS-1:0] mexp_q, mexp_d, mgot_q, mgot_d;
  logic                 done_q, done_d, timeout_q, timeout_d;
  logic [TO_W-1:0]      tcnt_q, tcnt_d;
  logic                 full_s, empty_s, push_s, cmp_s, pop_s;
  logic [DATA_BITS:0]   head_s;

  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign head_s  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_s  = exp_valid & ~full_s & ~clr;
  assign cmp_s   = evt_q & ~clr;
  // Once the last expected byte has been consumed, further frames count as extras.
  assign pop_s   = cmp_s & ~empty_s & ~done_q;

  // Scoreboard next state; clr wins over any push or received frame in the same cycle.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    match_d   = match_q;
    mis_d     = mis_q;
    extra_d   = extra_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    cmp_d     = cmp_q;
    midx_d    = midx_q;
    mexp_d    = mexp_q;
    mgot_d    = mgot_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    tcnt_d    = tcnt_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      match_d   = '0;
      mis_d     = '0;
      extra_d   = '0;
      ferr_d    = '0;
      perr_d    = '0;
      cmp_d     = '0;
      midx_d    = '0;
      mexp_d    = '0;
      mgot_d    = '0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      tcnt_d    = '0;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        cmp_d    = sat_inc(cmp_q);
        done_d   = done_q | head_s[DATA_BITS];
        if (head_s[DATA_BITS-1:0] == evt_data_q) begin
          match_d = sat_inc(match_q);
        end else begin
          mis_d = sat_inc(mis_q);
          if (mis_q == '0) begin
            midx_d = sat_inc(cmp_q);
            mexp_d = head_s[DATA_BITS-1:0];
            mgot_d = evt_data_q;
          end else begin
            midx_d = midx_q;
          end
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      extra_d = (cmp_s & ~pop_s)     ? sat_inc(extra_q) : extra_q;
      ferr_d  = (cmp_s & evt_ferr_q) ? sat_inc(ferr_q)  : ferr_q;
      perr_d  = (cmp_s & evt_perr_q) ? sat_inc(perr_q)  : perr_q;
      if (!empty_s && state_q == S_IDLE) begin
        tcnt_d    = (tcnt_q == TO_LIM) ? tcnt_q : tcnt_q + TO_W'(1);
        timeout_d = timeout_q | (tcnt_d == TO_LIM);
      end else begin
        tcnt_d = '0;
      end
    end
  end

  // Expected-byte storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {exp_last, exp_data};
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      match_q   <= '0;
      mis_q     <= '0;
      extra_q   <= '0;
      ferr_q    <= '0;
      perr_q    <= '0;
      cmp_q     <= '0;
      midx_q    <= '0;
      mexp_q    <= '0;
      mgot_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      match_q   <= match_d;
      mis_q     <= mis_d;
      extra_q   <= extra_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      cmp_q     <= cmp_d;
      midx_q    <= midx_d;
      mexp_q    <= mexp_d;
      mgot_q    <= mgot_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign exp_ready      = ~full_s;
  assign match_cnt      = match_q;
  assign mismatch_cnt   = mis_q;
  assign extra_cnt      = extra_q;
  assign frame_err_cnt  = ferr_q;
  assign parity_err_cnt = perr_q;
  assign mis_index      = midx_q;
  assign mis_exp        = mexp_q;
  assign mis_got        = mgot_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign pass = done_q & ~timeout_q & (mis_q == '0) & (extra_q == '0) & (ferr_q == '0) & (perr_q == '0);

endmodule

// File: tb/tb_uart_resp_checker.sv
// Bench for uart_resp_checker: a queue-based model of the expected stream checked every
// quiet cycle, plus directed scenarios on parity-enabled and short-timeout instances.
module tb_uart_resp_checker;

  localparam int BIT_CYC = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, clr, rxd_m, rxd_p, rxd_t;
  logic [7:0] exp_data, aux_data;
  logic exp_last, exp_valid, aux_last, aux_valid;

  logic        exp_ready, done, pass, timeout;
  logic [15:0] match_cnt, mismatch_cnt, extra_cnt, frame_err_cnt, parity_err_cnt, mis_index;
  logic [7:0]  mis_exp, mis_got;

  logic        p_ready, p_done, p_pass, p_to, t_ready, t_done, t_pass, t_to;
  logic [15:0] p_match, p_mis, p_extra, p_ferr, p_perr, p_midx;
  logic [15:0] t_match, t_mis, t_extra, t_ferr, t_perr, t_midx;
  logic [7:0]  p_mexp, p_mgot, t_mexp, t_mgot;

  uart_resp_checker dut (
    .clk(clk), .rstn(rstn), .rxd(rxd_m), .clr(clr),
    .exp_data(exp_data), .exp_last(exp_last), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .extra_cnt(extra_cnt),
    .frame_err_cnt(frame_err_cnt), .parity_err_cnt(parity_err_cnt),
    .mis_index(mis_index), .mis_exp(mis_exp), .mis_got(mis_got),
    .done(done), .pass(pass), .timeout(timeout)
  );

  uart_resp_checker #(.PARITY(2)) dut_p (
    .clk(clk), .rstn(rstn), .rxd(rxd_p), .clr(1'b0),
    .exp_data(aux_data), .exp_last(aux_last), .exp_valid(aux_valid), .exp_ready(p_ready),
    .match_cnt(p_match), .mismatch_cnt(p_mis), .extra_cnt(p_extra),
    .frame_err_cnt(p_ferr), .parity_err_cnt(p_perr),
    .mis_index(p_midx), .mis_exp(p_mexp), .mis_got(p_mgot),
    .done(p_done), .pass(p_pass), .timeout(p_to)
  );

  uart_resp_checker #(.TIMEOUT_CYC(100)) dut_t (
    .clk(clk), .rstn(rstn), .rxd(rxd_t), .clr(1'b0),
    .exp_data(aux_data), .exp_last(aux_last), .exp_valid(aux_valid), .exp_ready(t_ready),
    .match_cnt(t_match), .mismatch_cnt(t_mis), .extra_cnt(t_extra),
    .frame_err_cnt(t_ferr), .parity_err_cnt(t_perr),
    .mis_index(t_midx), .mis_exp(t_mexp), .mis_got(t_mgot),
    .done(t_done), .pass(t_pass), .timeout(t_to)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Expected-stream model: queue of {last, data} and the counters the rules imply.
  logic [8:0] m_q[$];
  int m_match, m_mis, m_extra, m_ferr, m_perr, m_cmp, m_idx;
  logic [7:0] m_exp, m_got;
  bit m_done;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_match = 0; m_mis = 0; m_extra = 0; m_ferr = 0; m_perr = 0; m_cmp = 0; m_idx = 0;
    m_exp = 8'h00; m_got = 8'h00; m_done = 1'b0;
  endfunction

  function automatic void model_event(input logic [7:0] d, input bit ferr, input bit perr);
    logic [8:0] e;
    if (ferr) m_ferr++;
    if (perr) m_perr++;
    if (m_q.size() == 0 || m_done) begin
      m_extra++;
    end else begin
      e = m_q.pop_front();
      m_cmp++;
      if (e[7:0] == d) begin
        m_match++;
      end else begin
        m_mis++;
        if (m_mis == 1) begin
          m_idx = m_cmp; m_exp = e[7:0]; m_got = d;
        end
      end
      if (e[8]) m_done = 1'b1;
    end
  endfunction

  // Continuous comparison of the main instance against the model while no frame is in flight.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("exp_ready", {31'd0, exp_ready}, {31'd0, (m_q.size() < 16)});
      chk("match_cnt", {16'd0, match_cnt}, m_match);
      chk("mismatch_cnt", {16'd0, mismatch_cnt}, m_mis);
      chk("extra_cnt", {16'd0, extra_cnt}, m_extra);
      chk("frame_err_cnt", {16'd0, frame_err_cnt}, m_ferr);
      chk("parity_err_cnt", {16'd0, parity_err_cnt}, m_perr);
      chk("mis_index", {16'd0, mis_index}, m_idx);
      chk("mis_exp", {24'd0, mis_exp}, {24'd0, m_exp});
      chk("mis_got", {24'd0, mis_got}, {24'd0, m_got});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("timeout", {31'd0, timeout}, 32'd0);
      chk("pass", {31'd0, pass},
          {31'd0, (m_done && m_mis == 0 && m_extra == 0 && m_ferr == 0 && m_perr == 0)});
    end
  end

  task automatic push(input logic [7:0] d, input logic last);
    @(negedge clk);
    exp_data = d; exp_last = last; exp_valid = 1'b1;
    @(posedge clk); #1;
    if (m_q.size() < 16) m_q.push_back({last, d});
    exp_valid = 1'b0;
  endtask

  task automatic do_clr(input bit with_push);
    @(negedge clk);
    clr = 1'b1;
    exp_data = 8'h11; exp_last = 1'b1; exp_valid = with_push;
    @(posedge clk); #1;
    model_clear();
    clr = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic set_rxd(input int which, input logic v);
    case (which)
      0:       rxd_m = v;
      1:       rxd_p = v;
      default: rxd_t = v;
    endcase
  endtask

  // One frame LSB first; a low stop bit is shortened so the line is high again before
  // the receiver's next half-bit check.
  task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop);
    set_rxd(which, 1'b0);
    repeat (BIT_CYC) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rxd(which, d[i]);
      repeat (BIT_CYC) @(posedge clk);
    end
    if (use_par) begin
      set_rxd(which, pbit);
      repeat (BIT_CYC) @(posedge clk);
    end
    set_rxd(which, stop);
    repeat (stop ? BIT_CYC : 40) @(posedge clk);
    set_rxd(which, 1'b1);
    repeat (BIT_CYC) @(posedge clk);
  endtask

  task automatic send_main(input logic [7:0] d, input logic stop);
    chk_en = 1'b0;
    send_frame(0, d, 1'b0, 1'b0, stop);
    model_event(d, !stop, 1'b0);
    chk_en = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; rxd_m = 1'b1; rxd_p = 1'b1; rxd_t = 1'b1;
    exp_data = 8'h00; exp_last = 1'b0; exp_valid = 1'b0;
    aux_data = 8'h00; aux_last = 1'b0; aux_valid = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk("reset exp_ready", {31'd0, exp_ready}, 32'd1);
    chk("reset match_cnt", {16'd0, match_cnt}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset pass", {31'd0, pass}, 32'd0);
    chk_en = 1'b1;

    // Two matching bytes end in done and pass.
    push(8'h41, 1'b0); push(8'h42, 1'b1);
    send_main(8'h41, 1'b1); send_main(8'h42, 1'b1);
    chk("basic match_cnt", {16'd0, match_cnt}, 32'd2);
    chk("basic done", {31'd0, done}, 32'd1);
    chk("basic pass", {31'd0, pass}, 32'd1);

    // Mismatch capture, then a frame after done counts as extra.
    do_clr(1'b0);
    push(8'h30, 1'b1);
    send_main(8'h31, 1'b1);
    chk("mis mismatch_cnt", {16'd0, mismatch_cnt}, 32'd1);
    chk("mis mis_index", {16'd0, mis_index}, 32'd1);
    chk("mis mis_exp", {24'd0, mis_exp}, 32'h30);
    chk("mis mis_got", {24'd0, mis_got}, 32'h31);
    chk("mis pass", {31'd0, pass}, 32'd0);
    send_main(8'h00, 1'b1);
    chk("after-done extra_cnt", {16'd0, extra_cnt}, 32'd1);

    // Fill the FIFO; the 17th push is dropped and the 17th frame is extra.
    do_clr(1'b0);
    for (int i = 0; i < 16; i++) push(8'(i * 7 + 3), (i == 15));
    @(negedge clk);
    chk("full exp_ready", {31'd0, exp_ready}, 32'd0);
    push(8'hEE, 1'b0);
    for (int i = 0; i < 17; i++) send_main(8'(i * 7 + 3), 1'b1);
    chk("full match_cnt", {16'd0, match_cnt}, 32'd16);
    chk("full extra_cnt", {16'd0, extra_cnt}, 32'd1);

    // clr beats a simultaneous push; the later frame finds an empty FIFO.
    do_clr(1'b1);
    send_main(8'h11, 1'b1);
    chk("clr-push extra_cnt", {16'd0, extra_cnt}, 32'd1);
    chk("clr-push match_cnt", {16'd0, match_cnt}, 32'd0);

    // Low stop bit: frame error counted, byte still compared.
    do_clr(1'b0);
    push(8'h5A, 1'b1);
    send_main(8'h5A, 1'b0);
    chk("ferr frame_err_cnt", {16'd0, frame_err_cnt}, 32'd1);
    chk("ferr match_cnt", {16'd0, match_cnt}, 32'd1);
    chk("ferr pass", {31'd0, pass}, 32'd0);

    // Parity and timeout instances share one pushed byte.
    @(negedge clk);
    aux_data = 8'h03; aux_last = 1'b1; aux_valid = 1'b1;
    @(posedge clk); #1;
    aux_valid = 1'b0;
    repeat (99) @(posedge clk); #1;
    chk("timeout at 99", {31'd0, t_to}, 32'd0);
    @(posedge clk); #1;
    chk("timeout at 100", {31'd0, t_to}, 32'd1);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0);
    chk("par parity_err_cnt", {16'd0, p_perr}, 32'd1);
    chk("par frame_err_cnt", {16'd0, p_ferr}, 32'd1);
    chk("par match_cnt", {16'd0, p_match}, 32'd1);
    rxd_t = 1'b0;
    repeat (20) @(posedge clk);
    rxd_t = 1'b1;
    repeat (200) @(posedge clk); #1;
    chk("glitch no event", {16'd0, t_match + t_mis + t_extra}, 32'd0);
    chk("glitch timeout sticky", {31'd0, t_to}, 32'd1);

    // Reset in the middle of the data bits, then a clean 0x55 frame.
    chk_en = 1'b0;
    push(8'h77, 1'b1);
    rxd_m = 1'b0; repeat (BIT_CYC) @(posedge clk);
    rxd_m = 1'b1; repeat (BIT_CYC) @(posedge clk);
    rxd_m = 1'b0; repeat (BIT_CYC) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rxd_m = 1'b1; rstn = 1'b1;
    model_clear();
    repeat (BIT_CYC * 12) @(posedge clk);
    @(negedge clk);
    chk("rst extra_cnt", {16'd0, extra_cnt}, 32'd0);
    chk_en = 1'b1;
    push(8'h55, 1'b1);
    send_main(8'h55, 1'b1);
    chk("rst match_cnt", {16'd0, match_cnt}, 32'd1);
    chk("rst events", {16'd0, match_cnt + mismatch_cnt + extra_cnt}, 32'd1);
    chk("rst pass", {31'd0, pass}, 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
